// File: rtl/reg_scoreboard_pkg.sv
// rtl/reg_scoreboard_pkg.sv - shared constants and helpers for the register write scoreboard
package reg_scoreboard_pkg;

    localparam int NREG       = 32;
    localparam int REG_IDX_W  = 5;
    localparam int CNT_W      = 2;
    localparam int TNEW_W     = 2;
    localparam int TUSE_W     = 2;

    // Cycles from E entry until the produced value can be forwarded
    localparam logic [TNEW_W-1:0] TNEW_JAL  = 2'd0;
    localparam logic [TNEW_W-1:0] TNEW_ALU  = 2'd1;
    localparam logic [TNEW_W-1:0] TNEW_LOAD = 2'd2;

    // Cycles until the D instruction consumes a source operand
    localparam logic [TUSE_W-1:0] TUSE_BR   = 2'd0;
    localparam logic [TUSE_W-1:0] TUSE_ALU  = 2'd1;
    localparam logic [TUSE_W-1:0] TUSE_ST   = 2'd2;
    localparam logic [TUSE_W-1:0] TUSE_NONE = 2'd3;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

endpackage

// File: rtl/reg_scoreboard_sb_entry.sv
// rtl/reg_scoreboard_sb_entry.sv - outstanding-write count and youngest-writer tnew for one register
module sb_entry
    import reg_scoreboard_pkg::*;
#(
    parameter int MAXPEND = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_hit,
    input  logic [TNEW_W-1:0] issue_tnew,
    input  logic              wb_hit,
    output logic [CNT_W-1:0]  cnt,
    output logic [TNEW_W-1:0] tnew,
    output logic              err
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAXPEND);

    logic [CNT_W-1:0]  cnt_nxt;
    logic [TNEW_W-1:0] tnew_nxt;

    always_comb begin
        cnt_nxt  = cnt;
        tnew_nxt = sat_dec(tnew);
        err      = 1'b0;
        if (issue_hit && wb_hit) begin
            // Net-zero change; a wb with nothing outstanding is still a protocol error
            tnew_nxt = issue_tnew;
            if (cnt == '0) begin
                cnt_nxt = CNT_W'(1);
                err     = 1'b1;
            end
        end else if (issue_hit) begin
            tnew_nxt = issue_tnew;
            if (cnt == MAX_CNT) begin
                err = 1'b1;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end else if (wb_hit) begin
            if (cnt == '0) begin
                err = 1'b1;
            end else begin
                cnt_nxt = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    tnew_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            tnew <= '0;
        end else begin
            cnt  <= cnt_nxt;
            tnew <= tnew_nxt;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - D-stage write hazard tracker with stall decision; MDU_BUSY_EN adds md_use/md_busy stall
module reg_scoreboard #(
    parameter int NREG    = reg_scoreboard_pkg::NREG,
    parameter int MAXPEND = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       issue_valid,
    input  logic [4:0] issue_rd,
    input  logic [1:0] issue_tnew,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [1:0] rs_tuse,
    input  logic [1:0] rt_tuse,
    input  logic       wb_valid,
    input  logic [4:0] wb_rd,
`ifdef MDU_BUSY_EN
    input  logic       md_use,
    input  logic       md_busy,
`endif
    output logic       stall,
    output logic       rs_pending,
    output logic       rt_pending,
    output logic       sb_err
);

    import reg_scoreboard_pkg::*;

    logic [CNT_W-1:0]  cnt_arr  [NREG];
    logic [TNEW_W-1:0] tnew_arr [NREG];
    logic [NREG-1:0]   err_vec;
    logic              issue_acc;
    logic              rs_hazard;
    logic              rt_hazard;
    logic              md_hazard;

    // Register 0 is hardwired zero and never tracked
    assign cnt_arr[0]  = '0;
    assign tnew_arr[0] = '0;
    assign err_vec[0]  = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_entry
        sb_entry #(
            .MAXPEND (MAXPEND)
        ) u_entry (
            .clk        (clk),
            .reset      (reset),
            .issue_hit  (issue_acc && (issue_rd == REG_IDX_W'(r))),
            .issue_tnew (issue_tnew),
            .wb_hit     (wb_valid && (wb_rd == REG_IDX_W'(r))),
            .cnt        (cnt_arr[r]),
            .tnew       (tnew_arr[r]),
            .err        (err_vec[r])
        );
    end

    assign rs_pending = (rs != '0) && (cnt_arr[rs] != '0);
    assign rt_pending = (rt != '0) && (cnt_arr[rt] != '0);

    // Stall only when the youngest writer cannot be forwarded by the time D needs it
    assign rs_hazard = rs_pending && (rs_tuse != TUSE_NONE) && (tnew_arr[rs] > rs_tuse);
    assign rt_hazard = rt_pending && (rt_tuse != TUSE_NONE) && (tnew_arr[rt] > rt_tuse);

`ifdef MDU_BUSY_EN
    assign md_hazard = md_use && md_busy;
`else
    assign md_hazard = 1'b0;
`endif

    assign stall     = rs_hazard || rt_hazard || md_hazard;
    assign issue_acc = issue_valid && !stall && (issue_rd != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err <= 1'b0;
        end else if (|err_vec) begin
            sb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - scoreboard-checked directed test of reg_scoreboard
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       issue_valid;
    logic [4:0] issue_rd;
    logic [1:0] issue_tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic       wb_valid;
    logic [4:0] wb_rd;
`ifdef MDU_BUSY_EN
    logic       md_use;
    logic       md_busy;
`endif
    logic       stall;
    logic       rs_pending;
    logic       rt_pending;
    logic       sb_err;

    typedef struct {
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_tnew  (issue_tnew),
        .rs          (rs),
        .rt          (rt),
        .rs_tuse     (rs_tuse),
        .rt_tuse     (rt_tuse),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
`ifdef MDU_BUSY_EN
        .md_use      (md_use),
        .md_busy     (md_busy),
`endif
        .stall       (stall),
        .rs_pending  (rs_pending),
        .rt_pending  (rt_pending),
        .sb_err      (sb_err)
    );

    // Monitor: pops one expectation per presented cycle and compares {stall, rs_p, rt_p, err}
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if ({stall, rs_pending, rt_pending, sb_err} !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got stall/rs_p/rt_p/err=%b required %b", e.name,
                         {stall, rs_pending, rt_pending, sb_err}, e.exp);
            end
        end
    end

    task automatic idle();
        issue_valid = 1'b0; issue_rd = 5'd0; issue_tnew = 2'd0;
        rs = 5'd0; rt = 5'd0; rs_tuse = 2'd3; rt_tuse = 2'd3;
        wb_valid = 1'b0; wb_rd = 5'd0;
`ifdef MDU_BUSY_EN
        md_use = 1'b0; md_busy = 1'b0;
`endif
    endtask

    task automatic iss(input logic [4:0] rd, input logic [1:0] tn);
        issue_valid = 1'b1; issue_rd = rd; issue_tnew = tn;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1'b1; wb_rd = rd;
    endtask

    task automatic rd_rs(input logic [4:0] r, input logic [1:0] tu);
        rs = r; rs_tuse = tu;
    endtask

    task automatic rd_rt(input logic [4:0] r, input logic [1:0] tu);
        rt = r; rt_tuse = tu;
    endtask

    // Queue the expectation for the current inputs, then advance one cycle
    task automatic cyc(input string name, input logic s, input logic rp, input logic tp, input logic e);
        exp_t x;
        x.exp  = {s, rp, tp, e};
        x.name = name;
        exp_q.push_back(x);
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        do_reset();

        rd_rs(5'd1, 2'd0); rd_rt(5'd2, 2'd0);              cyc("reset_state", 0, 0, 0, 0);
        // load then branch: two stall cycles
        iss(5'd1, 2'd2);                                   cyc("lw_issue",    0, 0, 0, 0);
        rd_rs(5'd1, 2'd0); rd_rt(5'd2, 2'd0);              cyc("lw_br_c1",    1, 1, 0, 0);
        rd_rs(5'd1, 2'd0); rd_rt(5'd2, 2'd0);              cyc("lw_br_c2",    1, 1, 0, 0);
        rd_rs(5'd1, 2'd0); rd_rt(5'd2, 2'd0);              cyc("lw_br_c3",    0, 1, 0, 0);
        wb(5'd1); rd_rs(5'd1, 2'd0);                       cyc("wb1_cycle",   0, 1, 0, 0);
        iss(5'd1, 2'd2); rd_rs(5'd1, 2'd0);                cyc("wb1_cleared", 0, 0, 0, 0);
        rd_rs(5'd1, 2'd2);                                 cyc("lw_store",    0, 1, 0, 0);
        wb(5'd1);                                          cyc("wb1_b",       0, 0, 0, 0);
        // ALU to ALU: forwarding covers it
        iss(5'd3, 2'd1);                                   cyc("addu3",       0, 0, 0, 0);
        rd_rs(5'd3, 2'd1); rd_rt(5'd3, 2'd1); iss(5'd4, 2'd1); cyc("alu_fwd", 0, 1, 1, 0);
        wb(5'd3); rd_rs(5'd4, 2'd1);                       cyc("alu_fwd4",    0, 1, 0, 0);
        wb(5'd4); rd_rs(5'd3, 2'd0);                       cyc("wb3_clear",   0, 0, 0, 0);
        // a stalled D instruction must not issue
        iss(5'd1, 2'd2);                                   cyc("lw1_again",   0, 0, 0, 0);
        rd_rs(5'd1, 2'd0); iss(5'd6, 2'd1);                cyc("blocked",     1, 1, 0, 0);
        rd_rt(5'd6, 2'd0);                                 cyc("no_issue6",   0, 0, 0, 0);
        wb(5'd1);                                          cyc("wb1_c",       0, 0, 0, 0);
        // two writers to $5
        iss(5'd5, 2'd2);                                   cyc("r5_i1",       0, 0, 0, 0);
        iss(5'd5, 2'd1);                                   cyc("r5_i2",       0, 0, 0, 0);
        wb(5'd5); rd_rs(5'd5, 2'd0);                       cyc("r5_young",    1, 1, 0, 0);
        rd_rs(5'd5, 2'd0);                                 cyc("r5_cnt1",     0, 1, 0, 0);
        wb(5'd5);                                          cyc("r5_wb2",      0, 0, 0, 0);
        rd_rs(5'd5, 2'd0); rd_rt(5'd5, 2'd3);              cyc("r5_clear",    0, 0, 0, 0);
        // same-cycle issue and wb
        iss(5'd7, 2'd0);                                   cyc("r7_i1",       0, 0, 0, 0);
        iss(5'd7, 2'd2); wb(5'd7);                         cyc("r7_iw",       0, 0, 0, 0);
        rd_rs(5'd7, 2'd1);                                 cyc("r7_tnew2",    1, 1, 0, 0);
        rd_rs(5'd7, 2'd1);                                 cyc("r7_tnew1",    0, 1, 0, 0);
        wb(5'd7); rd_rt(5'd7, 2'd0);                       cyc("r7_wb",       0, 0, 1, 0);
        // register 0 ignored
        iss(5'd0, 2'd2); wb(5'd0);                         cyc("r0_ops",      0, 0, 0, 0);
        rd_rs(5'd7, 2'd0);                                 cyc("r0_no_err",   0, 0, 0, 0);
        // underflow error
        wb(5'd9);                                          cyc("wb9_empty",   0, 0, 0, 0);
        rd_rs(5'd9, 2'd0);                                 cyc("err_set",     0, 0, 0, 1);
        cyc("err_hold", 0, 0, 0, 1);
        do_reset();
        rd_rs(5'd9, 2'd0); rd_rt(5'd1, 2'd0);              cyc("after_reset", 0, 0, 0, 0);
        // overflow error at MAXPEND
        iss(5'd8, 2'd0);                                   cyc("r8_i1",       0, 0, 0, 0);
        iss(5'd8, 2'd0);                                   cyc("r8_i2",       0, 0, 0, 0);
        iss(5'd8, 2'd0);                                   cyc("r8_i3",       0, 0, 0, 0);
        iss(5'd8, 2'd0); rd_rs(5'd8, 2'd3);                cyc("r8_i4",       0, 1, 0, 0);
        rd_rs(5'd8, 2'd0);                                 cyc("r8_ovf",      0, 1, 0, 1);
        do_reset();
        rd_rs(5'd8, 2'd0); rd_rt(5'd8, 2'd0);              cyc("reset_flush", 0, 1'b0, 1'b0, 0);
`ifdef MDU_BUSY_EN
        md_use = 1'b1; md_busy = 1'b1;                     cyc("md_stall",    1, 0, 0, 0);
        md_use = 1'b0; md_busy = 1'b1;                     cyc("md_nouse",    0, 0, 0, 0);
`endif

        @(negedge clk); #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d queued required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Write-side hazard tracker for the five-stage MIPS pipeline. It records every register write that has left D and not yet been committed by W, together with the cycles remaining until the value can be forwarded. It answers the D-stage register reads (rs/rt) with a single stall decision, so D reads the GRF only when the value is either committed or forwardable in time. It sits beside the D-stage decode and takes its clear events from the W-stage write port.

## Interface
Parameters:
- NREG, 32, number of architectural registers (index width 5)
- MAXPEND, 3, maximum in-flight writes per register (E, M, W)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- issue_valid  in  1  D instruction writes a register and wants to move to E
- issue_rd  in  5  destination register of the D instruction
- issue_tnew  in  2  cycles from E entry until result is forwardable (0 jal, 1 ALU, 2 load)
- rs  in  5  D-stage source register 1
- rt  in  5  D-stage source register 2
- rs_tuse  in  2  cycles until D instruction needs rs (0 branch/jr, 1 ALU, 2 store data); 3 = not used
- rt_tuse  in  2  same for rt
- wb_valid  in  1  W stage writes the GRF this cycle
- wb_rd  in  5  W-stage destination
- stall  out  1  freeze PC and F/D, insert bubble into E
- rs_pending  out  1  rs has an in-flight write (forward enable hint)
- rt_pending  out  1  same for rt
- sb_err  out  1  sticky protocol-error flag

## Operation
- Per register r: cnt[r] (2 bits, outstanding writes), tnew[r] (2 bits, youngest writer's remaining cycles).
- Register 0 is never tracked: issue or wb to 0 is ignored; rs/rt = 0 never pending.
- Hazard for rs: rs != 0, rs_tuse != 3, cnt[rs] != 0, tnew[rs] > rs_tuse. Same for rt. stall = rs hazard OR rt hazard.
- Issue accepted iff issue_valid && !stall && issue_rd != 0.
- Each cycle, for every r: tnew[r] decrements, saturating at 0. The pipeline past D always advances, because a stall inserts a bubble.
- Accepted issue to r: cnt[r] += 1; tnew[r] loads issue_tnew. The load overrides the decrement.
- wb_valid && wb_rd != 0: cnt[wb_rd] -= 1. If the result is 0, tnew is forced to 0.
- Issue and wb to the same register in the same cycle: cnt unchanged; tnew = issue_tnew.
- Errors set sb_err and keep it until reset:
  - Issue when cnt = MAXPEND: cnt saturates.
  - wb to a register with cnt = 0: cnt stays 0.
- rs_pending / rt_pending = cnt != 0 for a nonzero index.

## Timing
- stall, rs_pending, rt_pending: combinational from current state and D inputs, same cycle.
- State updates on posedge clk.
- An issue at edge k is visible to D reads in cycle k+1 with tnew = issue_tnew.
- A wb at edge k clears pending from cycle k+1. The W-to-D same-cycle GRF bypass is not this block's job.
- Reset: all cnt/tnew = 0, sb_err = 0, stall = 0, pending = 0. A reset mid-operation discards all in-flight entries.
- Latency from producer issue to consumer release = max(0, issue_tnew − tuse) stall cycles.

## Configuration
- MDU_BUSY_EN defined: adds inputs md_use (1, D instruction is mult/div/mfhi/mflo/mthi/mtlo) and md_busy (1, E-stage multiplier busy or starting).
  - stall additionally asserts when md_use && md_busy.
  - Issue is blocked as usual.
- MDU_BUSY_EN undefined: these ports are absent and stall is register-only.

## Structure
- define.v additions:
  - TNEW_* constants: TNEW_JAL 0, TNEW_ALU 1, TNEW_LOAD 2.
  - TUSE_* constants: TUSE_BR 0, TUSE_ALU 1, TUSE_ST 2, TUSE_NONE 3.
  - NREG.
- Sub-module sb_entry holds one register's cnt/tnew update logic. It is instantiated NREG−1 times in a generate loop.
- The top level holds the read muxes, stall OR, and sb_err.

## Test plan
- lw $1 issued (tnew 2), then D beq $1,$2 (rs_tuse 0): stall high 2 cycles, low on the third; no stall if rs_tuse 2.
- addu $3 issued (tnew 1), then D addu using $3 (tuse 1): stall never asserts; rs_pending = 1.
- Back-to-back issues to $5 (tnew 2, then 1), then wb $5 once: cnt = 1, pending stays high; second wb clears it.
- Same-cycle issue $7 and wb $7 with cnt = 1: cnt stays 1, tnew = issue_tnew; no sb_err.
- wb $9 with cnt 0 → sb_err = 1 held; reset → sb_err = 0, all pending = 0, stall = 0.
- MDU_BUSY_EN: md_busy = 1, md_use = 1 → stall = 1; md_use = 0 → stall = 0.
